rll_key_loader: RTL and testbench



---
 rtl/rll_key_pkg.sv | 22 ++
 rtl/rll_key_shreg.sv | 61 ++++++
 rtl/rll_key_loader.sv | 126 ++++++++++++
 tb/tb_rll_key_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the RLL key loader.
// Holds the loader state encoding, the default key width and the
// even-parity helper shared by the design and its bench.
package rll_key_pkg;

    localparam int KEY_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4
    } rll_key_state_e;

    // Even-parity bit for up to 64 data bits: the value that makes the
    // total count of ones (data plus parity) even. Zero-extend narrower data.
    function automatic logic even_parity(input logic [63:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/rll_key_shreg.sv
// Serial key staging: LSB-first shift register, bit counter, parity accumulator.
// Latency: one sample per enabled edge; o_done flags the edge capturing the parity bit.
// Backpressure: none; i_shift_en low holds all state for any number of cycles.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_clr         synchronous clear of staging, counter and accumulator (wins over shift)
//   i_shift_en    sample i_sdi on this edge
//   i_sdi         serial data, LSB first, parity bit last
//   o_staging     key bits captured so far
//   o_done        current enabled sample is the parity bit
//   o_parity_ok   accumulated parity over data plus parity bit is even
module rll_key_shreg
    import rll_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_shift_en,
    input  logic             i_sdi,
    output logic [KEY_W-1:0] o_staging,
    output logic             o_done,
    output logic             o_parity_ok
);

    localparam int CNT_W = $clog2(KEY_W + 2);

    logic [KEY_W-1:0] r_staging;
    logic [CNT_W-1:0] r_cnt;
    logic             r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staging <= '0;
            r_cnt     <= '0;
            r_acc     <= 1'b0;
        end else if (i_clr) begin
            r_staging <= '0;
            r_cnt     <= '0;
            r_acc     <= 1'b0;
        end else if (i_shift_en) begin
            // Only data bits enter the staging register; the parity bit
            // (sample KEY_W) only feeds the accumulator.
            if (r_cnt < CNT_W'(KEY_W)) begin
                r_staging <= {i_sdi, r_staging[KEY_W-1:1]};
            end
            r_acc <= even_parity(64'({r_acc, i_sdi}));
            // Saturate so the counter never passes KEY_W+1.
            if (r_cnt != CNT_W'(KEY_W + 1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_staging   = r_staging;
    assign o_done      = i_shift_en && (r_cnt == CNT_W'(KEY_W));
    assign o_parity_ok = ~r_acc;

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader: shifts key+parity in, checks even parity, commits key atomically.
// Latency: start edge + KEY_W+1 enabled samples + one check edge (19 edges for KEY_W=16).
// Backpressure: key_sen low stalls the shift indefinitely; start ignored while busy/locked.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       request a new load (accepted in IDLE and ERROR)
//   key_sen     shift enable, key_sdi sampled when high in SHIFT
//   key_sdi     serial key data, LSB first, parity bit last
//   key_clr     synchronous clear, top priority, returns to IDLE
//   key_out     committed key (zero unless a parity-checked key is held)
//   key_valid   key_out holds a parity-checked key
//   busy        high while in SHIFT or CHECK
//   err         last load failed parity, sticky until start or key_clr
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             key_sen,
    input  logic             key_sdi,
    input  logic             key_clr,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    rll_key_state_e   r_state;
    logic [KEY_W-1:0] r_key_out;
    logic             r_key_valid;
    logic             r_busy;
    logic             r_err;

    logic [KEY_W-1:0] w_staging;
    logic             w_done;
    logic             w_parity_ok;
    logic             w_shift_en;
    logic             w_sr_clr;

    assign w_shift_en = (r_state == ST_SHIFT) && key_sen && !key_clr;
    // Staging is wiped whenever a new load is accepted so a retry from
    // ERROR never inherits bits from the failed attempt.
    assign w_sr_clr   = key_clr ||
                        (start && ((r_state == ST_IDLE) || (r_state == ST_ERROR)));

    rll_key_shreg #(
        .KEY_W (KEY_W)
    ) u_shreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_sr_clr),
        .i_shift_en  (w_shift_en),
        .i_sdi       (key_sdi),
        .o_staging   (w_staging),
        .o_done      (w_done),
        .o_parity_ok (w_parity_ok)
    );

    // busy is updated alongside every state transition so it reflects
    // the state being entered, keeping it a pure register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else if (key_clr) begin
            r_state     <= ST_IDLE;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_done) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_busy <= 1'b0;
                    if (w_parity_ok) begin
                        // The only path that loads a nonzero key.
                        r_key_out   <= w_staging;
                        r_key_valid <= 1'b1;
                        r_state     <= ST_LOCKED;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERROR;
                    end
                end
                ST_LOCKED: begin
                    r_state <= ST_LOCKED;
                end
                ST_ERROR: begin
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign key_out   = r_key_out;
    assign key_valid = r_key_valid;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: each task drives one scenario and
// checks outputs 1 time unit after the rising edge.
module tb_rll_key_loader;
    import rll_key_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        key_sen;
    logic        key_sdi;
    logic        key_clr;
    logic [15:0] key_out;
    logic        key_valid;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    rll_key_loader #(.KEY_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_sen   (key_sen),
        .key_sdi   (key_sdi),
        .key_clr   (key_clr),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift 16 data bits LSB first then the parity bit; with gaps, each
    // enabled sample is preceded by one key_sen=0 cycle.
    task automatic shift_key(input logic [15:0] k, input logic par, input bit gaps,
                             output bit saw_nonzero);
        logic [16:0] s;
        s = {par, k};
        saw_nonzero = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (gaps) begin
                key_sen = 1'b0;
                key_sdi = ~s[i];
                tick();
                if (key_out !== 16'h0) saw_nonzero = 1'b1;
            end
            key_sen = 1'b1;
            key_sdi = s[i];
            tick();
            if (key_out !== 16'h0) saw_nonzero = 1'b1;
        end
        key_sen = 1'b0;
        key_sdi = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        key_clr = 1'b1;
        tick();
        key_clr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (key_out !== 16'h0) begin n_fail++; $display("FAIL reset_key_out got %h want 0000", key_out); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        bit nz;
        pulse_start();                                   // edge 1
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_shift got %b want 1", busy); end
        shift_key(16'hA5C3, 1'b0, 1'b0, nz);             // edges 2..18
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_edge18 got %b want 0", key_valid); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_check got %b want 1", busy); end
        tick();                                          // edge 19
        n_tests++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_edge19 got %b want 1", key_valid); end
        n_tests++; if (key_out !== 16'hA5C3) begin n_fail++; $display("FAIL basic_key_out got %h want a5c3", key_out); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_locked got %b want 0", busy); end
        pulse_clr();
    endtask

    task automatic test_parity_error();
        bit nz;
        pulse_start();
        shift_key(16'h0001, 1'b0, 1'b0, nz);
        tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL perr_err got %b want 1", err); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL perr_valid got %b want 0", key_valid); end
        n_tests++; if (key_out !== 16'h0) begin n_fail++; $display("FAIL perr_key_out got %h want 0000", key_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL perr_busy got %b want 0", busy); end
        pulse_start();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_retry_err got %b want 0", err); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL perr_retry_busy got %b want 1", busy); end
        shift_key(16'h0001, 1'b1, 1'b0, nz);
        tick();
        n_tests++; if (key_out !== 16'h0001) begin n_fail++; $display("FAIL perr_retry_key_out got %h want 0001", key_out); end
        n_tests++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL perr_retry_valid got %b want 1", key_valid); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_retry_err2 got %b want 0", err); end
        pulse_clr();
    endtask

    task automatic test_gapped_shift();
        bit nz;
        pulse_start();
        shift_key(16'hFFFF, 1'b0, 1'b1, nz);
        n_tests++; if (nz !== 1'b0) begin n_fail++; $display("FAIL gap_key_out_during_shift got %b want 0", nz); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid_before_commit got %b want 0", key_valid); end
        tick();
        n_tests++; if (key_out !== 16'hFFFF) begin n_fail++; $display("FAIL gap_key_out got %h want ffff", key_out); end
        n_tests++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got %b want 1", key_valid); end
        pulse_clr();
    endtask

    task automatic test_locked_hold();
        bit nz;
        pulse_start();
        shift_key(16'h1234, 1'b1, 1'b0, nz);
        tick();
        n_tests++; if (key_out !== 16'h1234) begin n_fail++; $display("FAIL lock_load got %h want 1234", key_out); end
        pulse_start();
        shift_key(16'h5A5A, even_parity(64'h5A5A), 1'b0, nz);
        tick();
        tick();
        n_tests++; if (key_out !== 16'h1234) begin n_fail++; $display("FAIL lock_hold_key_out got %h want 1234", key_out); end
        n_tests++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL lock_hold_valid got %b want 1", key_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_hold_busy got %b want 0", busy); end
        pulse_clr();
        n_tests++; if (key_out !== 16'h0) begin n_fail++; $display("FAIL lock_clr_key_out got %h want 0000", key_out); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL lock_clr_valid got %b want 0", key_valid); end
        // Back in IDLE: a start on the next edge must be accepted.
        pulse_start();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lock_clr_idle_start got busy %b want 1", busy); end
        pulse_clr();
    endtask

    task automatic test_reset_mid_shift();
        bit nz;
        logic [15:0] k;
        k = 16'hBEEF;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            key_sen = 1'b1;
            key_sdi = k[i];
            tick();
        end
        key_sen = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_tests++; if (key_out !== 16'h0) begin n_fail++; $display("FAIL rst_mid_key_out got %h want 0000", key_out); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", key_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        shift_key(16'h1357, 1'b0, 1'b0, nz);
        tick();
        n_tests++; if (key_out !== 16'h1357) begin n_fail++; $display("FAIL rst_mid_reload got %h want 1357", key_out); end
        n_tests++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reload_valid got %b want 1", key_valid); end
        pulse_clr();
    endtask

    task automatic test_clr_start_same_edge();
        key_clr = 1'b1;
        start   = 1'b1;
        tick();
        key_clr = 1'b0;
        start   = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_start_busy got %b want 0", busy); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_start_busy_next got %b want 0", busy); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL clr_start_valid got %b want 0", key_valid); end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        key_sen = 1'b0;
        key_sdi = 1'b0;
        key_clr = 1'b0;
        test_reset();
        test_basic_load();
        test_parity_error();
        test_gapped_shift();
        test_locked_hold();
        test_reset_mid_shift();
        test_clr_start_same_edge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
